sdram_arbiter: RTL and testbench
================================

# sdram_arbiter

Two-port arbiter that shares the single SDRAM command/read-data path between the 6502 bus side (port 0) and a second bus master (port 1, e.g. DMA or video fetch). It sits between the requesters and the SDRAM controller command interface. It grants one single-word transaction at a time using round-robin on ties, and holds off all grants until SDRAM initialisation completes. It also bounds every read with a timeout so a lost read response cannot hang a requester.

## Interface
Parameters:
- ADDR_W, 24, SDRAM word address width.
- DATA_W, 8, data width per transaction.
- TIMEOUT, 255, max cycles waiting for read data after command accept (1..2^16-1).

Ports:
- clk  in  1  single clock for all logic.
- reset  in  1  synchronous, active-high reset.
- i_init_done  in  1  SDRAM init complete; no grant while low.
- i_req0 / i_req1  in  1  request, level, held until matching ack.
- i_we0 / i_we1  in  1  1 = write, 0 = read; stable while req high.
- i_addr0 / i_addr1  in  ADDR_W  address; stable while req high.
- i_wdata0 / i_wdata1  in  DATA_W  write data; stable while req high.
- o_ack0 / o_ack1  out  1  one-cycle completion pulse.
- o_rdata0 / o_rdata1  out  DATA_W  read data, valid with ack, held afterwards.
- o_err0 / o_err1  out  1  one-cycle pulse coincident with ack on read timeout.
- o_cmd_valid  out  1  command valid to SDRAM controller.
- i_cmd_ready  in  1  controller accepts command when valid && ready.
- o_cmd_we, o_cmd_addr[ADDR_W], o_cmd_wdata[DATA_W]  out  command fields, registered, stable while o_cmd_valid.
- i_rd_valid  in  1  read data return strobe, one cycle.
- i_rd_data  in  DATA_W  read data, valid with i_rd_valid.
- o_busy  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, ISSUE, WAIT_RD, DONE. Register `owner` holds the granted port. Register `last` holds the previous owner.
- IDLE: if i_init_done and any request is high:
  - One request high: grant that port.
  - Both high: grant the port that is not `last`.
  - On grant: latch we, addr and wdata into the cmd registers, set `owner`, set `last` = owner, go to ISSUE.
- ISSUE: o_cmd_valid = 1.
  - On i_cmd_ready with a write: go to DONE.
  - On i_cmd_ready with a read: clear the timeout counter and go to WAIT_RD.
  - If ready is not seen, stay in ISSUE. There is no limit on waiting for ready.
- WAIT_RD:
  - On i_rd_valid: capture i_rd_data into o_rdata[owner] and go to DONE.
  - Otherwise increment the counter. When the counter reaches TIMEOUT-1 without rd_valid: load o_rdata[owner] = all ones, flag error, go to DONE.
- DONE: o_ack[owner] = 1 for this cycle only. o_err[owner] = 1 if the error flag is set. Clear the flag and go to IDLE.
- i_rd_valid is ignored in IDLE, ISSUE and DONE. This covers stale responses from timed-out reads or reads from before a reset.
- A request still high in the IDLE cycle after its ack is treated as a new transaction. Requesters drop req on the cycle ack is seen.
- The non-owner port's outputs are unaffected while the other port is being served.
- i_init_done falling: it only blocks new grants. An in-flight transaction completes normally.

## Timing
- Reset values:
  - State IDLE, `last` = 1, so port 0 wins the first tie.
  - All ack and err outputs 0, o_cmd_valid 0.
  - o_cmd_we/addr/wdata 0, o_rdata0/1 0, o_busy 0, counter 0.
- Reset mid-transaction: returns to IDLE on the next edge, with no ack and no err.
- Write, ready tied high, request seen in cycle 0:
  - o_cmd_valid in cycle 1.
  - o_ack in cycle 2.
  - o_busy high in cycles 1–2.
  - Minimum 3 cycles between back-to-back grants.
- Read, ready tied high, i_rd_valid in cycle 1+L (L ≥ 1 cycles after accept): o_ack and o_rdata valid in cycle 2+L.
- Read timeout: with no i_rd_valid, ack + err occur TIMEOUT+1 cycles after the accept cycle.
- Counter width: ceil(log2(TIMEOUT+1)). It never wraps because the timeout exits first.
- All outputs are registered except o_busy, which is decoded from state.

## Test plan
- Reset with i_init_done = 0 and i_req0 = 1 -> no o_cmd_valid. Raise i_init_done -> o_cmd_valid next cycle with port-0 fields.
- Port 0 writes addr 0x000123, data 0xA5; ready high -> cmd we = 1, addr 0x000123, wdata 0xA5; o_ack0 exactly 2 cycles after req; o_ack1 stays 0.
- Port 1 reads addr 0x00FFFF; rd_valid with 0x3C 4 cycles after accept -> o_rdata1 = 0x3C with o_ack1; o_rdata0 unchanged.
- Both requests held continuously, each dropping for one cycle after its ack and re-raising -> grants alternate 0,1,0,1. With ready low for 5 cycles in ISSUE, cmd fields stay stable and o_cmd_valid stays high.
- TIMEOUT = 8, read with no rd_valid -> o_ack0 + o_err0 9 cycles after accept, o_rdata0 = 0xFF. A late rd_valid afterwards is ignored.
- Assert reset while in WAIT_RD -> IDLE next cycle, no ack. A subsequent stale rd_valid is ignored; the next read returns correct data.

Source files
------------

// File: rtl/sdram_arbiter.sv
// Two-port single-word arbiter in front of the SDRAM controller command path.
// Round-robin on ties, grants held off until init, reads bounded by a timeout.
module sdram_arbiter #(
    parameter int ADDR_W  = 24,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_init_done,
    input  logic              i_req0,
    input  logic              i_we0,
    input  logic [ADDR_W-1:0] i_addr0,
    input  logic [DATA_W-1:0] i_wdata0,
    input  logic              i_req1,
    input  logic              i_we1,
    input  logic [ADDR_W-1:0] i_addr1,
    input  logic [DATA_W-1:0] i_wdata1,
    output logic              o_ack0,
    output logic [DATA_W-1:0] o_rdata0,
    output logic              o_err0,
    output logic              o_ack1,
    output logic [DATA_W-1:0] o_rdata1,
    output logic              o_err1,
    output logic              o_cmd_valid,
    input  logic              i_cmd_ready,
    output logic              o_cmd_we,
    output logic [ADDR_W-1:0] o_cmd_addr,
    output logic [DATA_W-1:0] o_cmd_wdata,
    input  logic              i_rd_valid,
    input  logic [DATA_W-1:0] i_rd_data,
    output logic              o_busy
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_RD,
        DONE
    } state_t;

    state_t           state;
    logic             owner;
    logic             last;
    logic [CNT_W-1:0] cnt;
    logic             pick;
    logic             grant;
    logic             tmo;

    // On a tie the port that was not served last wins.
    always_comb begin
        pick = i_req1;
        if (i_req0 && i_req1) begin
            pick = ~last;
        end
    end

    assign grant  = i_init_done && (i_req0 || i_req1);
    assign tmo    = (cnt == CNT_W'(TIMEOUT - 1));
    assign o_busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            owner       <= 1'b0;
            last        <= 1'b1;
            cnt         <= '0;
            o_ack0      <= 1'b0;
            o_ack1      <= 1'b0;
            o_err0      <= 1'b0;
            o_err1      <= 1'b0;
            o_rdata0    <= '0;
            o_rdata1    <= '0;
            o_cmd_valid <= 1'b0;
            o_cmd_we    <= 1'b0;
            o_cmd_addr  <= '0;
            o_cmd_wdata <= '0;
        end else begin
            o_ack0 <= 1'b0;
            o_ack1 <= 1'b0;
            o_err0 <= 1'b0;
            o_err1 <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (grant) begin
                        owner       <= pick;
                        last        <= pick;
                        o_cmd_valid <= 1'b1;
                        o_cmd_we    <= pick ? i_we1 : i_we0;
                        o_cmd_addr  <= pick ? i_addr1 : i_addr0;
                        o_cmd_wdata <= pick ? i_wdata1 : i_wdata0;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (i_cmd_ready) begin
                        o_cmd_valid <= 1'b0;
                        if (o_cmd_we) begin
                            o_ack0 <= ~owner;
                            o_ack1 <= owner;
                            state  <= DONE;
                        end else begin
                            cnt   <= '0;
                            state <= WAIT_RD;
                        end
                    end
                end
                WAIT_RD: begin
                    if (i_rd_valid) begin
                        if (owner) o_rdata1 <= i_rd_data;
                        else       o_rdata0 <= i_rd_data;
                        o_ack0 <= ~owner;
                        o_ack1 <= owner;
                        state  <= DONE;
                    end else if (tmo) begin
                        if (owner) o_rdata1 <= '1;
                        else       o_rdata0 <= '1;
                        o_ack0 <= ~owner;
                        o_ack1 <= owner;
                        o_err0 <= ~owner;
                        o_err1 <= owner;
                        state  <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter with a short read timeout.
module tb_sdram_arbiter;

    localparam int AW = 24;
    localparam int DW = 8;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          init_done;
    logic          req0, we0, req1, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          ack0, ack1, err0, err1;
    logic [DW-1:0] rdata0, rdata1;
    logic          cmd_valid, cmd_ready, cmd_we;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic          busy;

    int errors = 0;
    int checks = 0;

    sdram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .i_init_done(init_done),
        .i_req0(req0), .i_we0(we0), .i_addr0(addr0), .i_wdata0(wdata0),
        .i_req1(req1), .i_we1(we1), .i_addr1(addr1), .i_wdata1(wdata1),
        .o_ack0(ack0), .o_rdata0(rdata0), .o_err0(err0),
        .o_ack1(ack1), .o_rdata1(rdata1), .o_err1(err1),
        .o_cmd_valid(cmd_valid), .i_cmd_ready(cmd_ready),
        .o_cmd_we(cmd_we), .o_cmd_addr(cmd_addr), .o_cmd_wdata(cmd_wdata),
        .i_rd_valid(rd_valid), .i_rd_data(rd_data), .o_busy(busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; init_done = 1'b0; cmd_ready = 1'b1;
        req0 = 1'b1; we0 = 1'b1; addr0 = 24'h000456; wdata0 = 8'h5C;
        step();
        step();
        reset = 1'b0;
        checks++;
        if ({cmd_valid, ack0, ack1, err0, err1, busy} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctl: got %b want 000000",
                     {cmd_valid, ack0, ack1, err0, err1, busy});
        end
        checks++;
        if ({rdata0, rdata1, cmd_we, cmd_addr, cmd_wdata} !== '0) begin
            errors++;
            $display("FAIL reset_data: got %h want 0",
                     {rdata0, rdata1, cmd_we, cmd_addr, cmd_wdata});
        end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (cmd_valid !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL init_block: got valid=%b busy=%b want 0 0",
                         cmd_valid, busy);
            end
        end
        init_done = 1'b1;
        step();
        checks++;
        if ({cmd_valid, cmd_we, cmd_addr, cmd_wdata} !== {1'b1, 1'b1, 24'h000456, 8'h5C}) begin
            errors++;
            $display("FAIL init_grant: got v=%b we=%b a=%h d=%h want 1 1 000456 5c",
                     cmd_valid, cmd_we, cmd_addr, cmd_wdata);
        end
        step();
        req0 = 1'b0;
        checks++;
        if (ack0 !== 1'b1) begin
            errors++;
            $display("FAIL init_ack: got %b want 1", ack0);
        end
        step();
    endtask

    task automatic test_write();
        req0 = 1'b1; we0 = 1'b1; addr0 = 24'h000123; wdata0 = 8'hA5;
        cmd_ready = 1'b1;
        step();
        checks++;
        if ({cmd_valid, cmd_we, cmd_addr, cmd_wdata, ack0, busy} !==
            {1'b1, 1'b1, 24'h000123, 8'hA5, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL wr_cmd: got v=%b we=%b a=%h d=%h ack0=%b busy=%b want 1 1 000123 a5 0 1",
                     cmd_valid, cmd_we, cmd_addr, cmd_wdata, ack0, busy);
        end
        step();
        req0 = 1'b0;
        checks++;
        if ({ack0, ack1, err0, busy, cmd_valid} !== 5'b10010) begin
            errors++;
            $display("FAIL wr_ack: got %b want 10010",
                     {ack0, ack1, err0, busy, cmd_valid});
        end
        step();
        checks++;
        if ({ack0, ack1, busy} !== 3'b000) begin
            errors++;
            $display("FAIL wr_idle: got %b want 000", {ack0, ack1, busy});
        end
    endtask

    task automatic test_timeout();
        req0 = 1'b1; we0 = 1'b0; addr0 = 24'h000042;
        cmd_ready = 1'b1; rd_valid = 1'b0;
        step();
        checks++;
        if (cmd_valid !== 1'b1 || cmd_we !== 1'b0) begin
            errors++;
            $display("FAIL to_cmd: got v=%b we=%b want 1 0", cmd_valid, cmd_we);
        end
        for (int c = 2; c < TO + 2; c++) begin
            step();
            checks++;
            if (ack0 !== 1'b0 || err0 !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL to_wait c%0d: got ack=%b err=%b busy=%b want 0 0 1",
                         c, ack0, err0, busy);
            end
        end
        step();
        req0 = 1'b0;
        checks++;
        if ({ack0, err0, ack1, err1, rdata0} !== {4'b1100, 8'hFF}) begin
            errors++;
            $display("FAIL to_ack: got ack=%b err=%b ack1=%b err1=%b rd=%h want 1 1 0 0 ff",
                     ack0, err0, ack1, err1, rdata0);
        end
        step();
        rd_valid = 1'b1; rd_data = 8'h11;
        step();
        rd_valid = 1'b0;
        checks++;
        if ({ack0, err0, busy, rdata0} !== {3'b000, 8'hFF}) begin
            errors++;
            $display("FAIL to_late: got ack=%b err=%b busy=%b rd=%h want 0 0 0 ff",
                     ack0, err0, busy, rdata0);
        end
    endtask

    task automatic test_read();
        req1 = 1'b1; we1 = 1'b0; addr1 = 24'h00FFFF;
        cmd_ready = 1'b1; rd_valid = 1'b0;
        step();
        checks++;
        if ({cmd_valid, cmd_we, cmd_addr} !== {1'b1, 1'b0, 24'h00FFFF}) begin
            errors++;
            $display("FAIL rd_cmd: got v=%b we=%b a=%h want 1 0 00ffff",
                     cmd_valid, cmd_we, cmd_addr);
        end
        for (int c = 2; c <= 5; c++) begin
            step();
            checks++;
            if (ack1 !== 1'b0) begin
                errors++;
                $display("FAIL rd_wait c%0d: got ack1=%b want 0", c, ack1);
            end
        end
        rd_valid = 1'b1; rd_data = 8'h3C;
        step();
        rd_valid = 1'b0;
        req1 = 1'b0;
        checks++;
        if ({ack1, err1, ack0, rdata1, rdata0} !== {3'b100, 8'h3C, 8'hFF}) begin
            errors++;
            $display("FAIL rd_ack: got ack1=%b err1=%b ack0=%b rd1=%h rd0=%h want 1 0 0 3c ff",
                     ack1, err1, ack0, rdata1, rdata0);
        end
        step();
    endtask

    task automatic test_round_robin();
        logic    prev_v;
        int      g;
        int      stall;
        logic [AW-1:0] exp_a;
        req0 = 1'b1; we0 = 1'b1; addr0 = 24'h000010; wdata0 = 8'h55;
        req1 = 1'b1; we1 = 1'b1; addr1 = 24'h000020; wdata1 = 8'hAA;
        cmd_ready = 1'b0;
        prev_v = 1'b0; g = 0; stall = 0;
        for (int c = 0; c < 80 && g < 4; c++) begin
            step();
            if (cmd_valid && !prev_v) begin
                exp_a = (g % 2 == 0) ? 24'h000010 : 24'h000020;
                checks++;
                if (cmd_addr !== exp_a) begin
                    errors++;
                    $display("FAIL rr_grant%0d: got addr=%h want %h", g, cmd_addr, exp_a);
                end
                g++;
            end
            if (g == 1 && stall < 5 && cmd_valid !== 1'b0 && ack0 !== 1'b1) begin
                if (stall > 0) begin
                    checks++;
                    if ({cmd_valid, cmd_addr, cmd_wdata} !== {1'b1, 24'h000010, 8'h55}) begin
                        errors++;
                        $display("FAIL rr_stall%0d: got v=%b a=%h d=%h want 1 000010 55",
                                 stall, cmd_valid, cmd_addr, cmd_wdata);
                    end
                end
                cmd_ready = 1'b0;
                stall++;
            end else begin
                cmd_ready = 1'b1;
            end
            req0 = ~ack0;
            req1 = ~ack1;
            prev_v = cmd_valid;
        end
        checks++;
        if (g != 4 || stall != 5) begin
            errors++;
            $display("FAIL rr_count: got grants=%0d stalls=%0d want 4 5", g, stall);
        end
        req0 = 1'b0; req1 = 1'b0; cmd_ready = 1'b1;
        for (int i = 0; i < 4; i++) step();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL rr_drain: got busy=%b want 0", busy);
        end
    endtask

    task automatic test_reset_midread();
        req0 = 1'b1; we0 = 1'b0; addr0 = 24'h000077;
        cmd_ready = 1'b1; rd_valid = 1'b0;
        step();
        step();
        step();
        reset = 1'b1; req0 = 1'b0;
        step();
        reset = 1'b0;
        checks++;
        if ({busy, ack0, err0, cmd_valid, rdata0} !== {4'b0000, 8'h00}) begin
            errors++;
            $display("FAIL mid_reset: got busy=%b ack=%b err=%b v=%b rd=%h want 0 0 0 0 00",
                     busy, ack0, err0, cmd_valid, rdata0);
        end
        rd_valid = 1'b1; rd_data = 8'h99;
        step();
        rd_valid = 1'b0;
        checks++;
        if ({busy, ack0, rdata0} !== {2'b00, 8'h00}) begin
            errors++;
            $display("FAIL stale_rd: got busy=%b ack=%b rd=%h want 0 0 00",
                     busy, ack0, rdata0);
        end
        req0 = 1'b1; addr0 = 24'h000078;
        step();
        checks++;
        if ({cmd_valid, cmd_we, cmd_addr} !== {1'b1, 1'b0, 24'h000078}) begin
            errors++;
            $display("FAIL rd2_cmd: got v=%b we=%b a=%h want 1 0 000078",
                     cmd_valid, cmd_we, cmd_addr);
        end
        step();
        rd_valid = 1'b1; rd_data = 8'h5A;
        step();
        rd_valid = 1'b0; req0 = 1'b0;
        checks++;
        if ({ack0, err0, rdata0} !== {2'b10, 8'h5A}) begin
            errors++;
            $display("FAIL rd2_ack: got ack=%b err=%b rd=%h want 1 0 5a",
                     ack0, err0, rdata0);
        end
        step();
        checks++;
        if ({ack0, busy} !== 2'b00) begin
            errors++;
            $display("FAIL rd2_idle: got ack=%b busy=%b want 0 0", ack0, busy);
        end
    endtask

    initial begin
        reset = 1'b1; init_done = 1'b0;
        req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
        req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
        cmd_ready = 1'b0; rd_valid = 1'b0; rd_data = '0;
        test_reset();
        test_write();
        test_timeout();
        test_read();
        test_round_robin();
        test_reset_midread();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
